// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: word/block types, key-schedule FSM states,
// round constants and the forward S-box table.
package aes128_pkg;

    localparam int AES_ROUNDS = 10;
    localparam int AES_KEY_W  = 128;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ks_state_t;

    // Entry i holds the round constant for round i+1.
    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant for a 1-based round number; 0 outside 1..10.
    function automatic logic [7:0] rcon_of(input logic [3:0] round);
        logic [3:0] idx;
        idx = round - 4'd1;
        if ((round >= 4'd1) && (round <= 4'(AES_ROUNDS)))
            return RCON[idx];
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Combinational AES forward S-box for a single byte.
module aes_sbox_byte
    import aes128_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = SBOX[a];

endmodule

// File: rtl/aes128_key_schedule.sv
// Iterative AES-128 key expansion: emits round keys 0..10 one per
// rk_valid/rk_ready handshake and holds the round-10 key on last_key.
module aes128_key_schedule
    import aes128_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [3:0]       rk_round,
    output logic [KEY_W-1:0] round_key,
    output logic [KEY_W-1:0] last_key,
    output logic             done
);

    generate
        if ((NUM_ROUNDS != AES_ROUNDS) || (KEY_W != AES_KEY_W)) begin : g_bad_params
            $error("aes128_key_schedule supports only NUM_ROUNDS=10 and KEY_W=128");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    ks_state_t state;

    word_t      w0, w1, w2, w3;
    word_t      rot_w, sub_w, temp;
    word_t      n0, n1, n2, n3;
    logic [3:0] next_round;
    logic [7:0] rcon;
    block_t     next_key;

    assign {w0, w1, w2, w3} = round_key;
    assign rot_w            = {w3[23:0], w3[31:24]};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_subword
            aes_sbox_byte u_sbox (
                .a (rot_w[8*i +: 8]),
                .y (sub_w[8*i +: 8])
            );
        end
    endgenerate

    assign next_round = rk_round + 4'd1;
    assign rcon       = rcon_of(next_round);
    assign temp       = sub_w ^ {rcon, 24'h000000};
    assign n0         = w0 ^ temp;
    assign n1         = w1 ^ n0;
    assign n2         = w2 ^ n1;
    assign n3         = w3 ^ n2;
    assign next_key   = {n0, n1, n2, n3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            rk_round  <= 4'd0;
            round_key <= '0;
            last_key  <= '0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here, so every branch reads the
            // pre-edge round_key/rk_round and the default below is overridable.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        rk_round  <= 4'd0;
                        rk_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_valid && rk_ready) begin
                        if (rk_round == LAST_ROUND) begin
                            last_key <= round_key;
                            done     <= 1'b1;
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            round_key <= next_key;
                            rk_round  <= next_round;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes128_key_schedule.md
Name: aes128_key_schedule

Overview:
- Iterative AES-128 key expansion. Produces round keys 0..10 in order, one per accepted handshake.
- Sits directly upstream of the encryption round units. The final round unit consumes the round-10 key.
- The round-10 key is also held on a stable output until the next expansion, so the final round can use it as a static key.
- Each round key needs one cycle of combinational SubWord/RotWord/Rcon logic, then a register stage.

Parameters:
- NUM_ROUNDS, 10, number of round keys after round 0. Fixed at 10 for AES-128; any other value is unsupported and must fail elaboration.
- KEY_W, 128, key and round-key width in bits. Fixed at 128.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new expansion. Sampled only in IDLE.
- key_in  input  128  cipher key. Sampled on the cycle start is accepted. Bits [127:96] are word w0.
- busy  output  1  high while an expansion is in progress (state EMIT)
- rk_valid  output  1  round_key/rk_round are valid
- rk_ready  input  1  consumer accepts the current round key
- rk_round  output  4  index of the current round key, 0..10
- round_key  output  128  current round key
- last_key  output  128  round-10 key of the most recent completed expansion. Stable until the next completion.
- done  output  1  one-cycle pulse after round 10 is accepted

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, rk_valid=0, done=0.
  - rk_round=0, round_key=0, last_key=0.
  - Applies immediately, including mid-expansion. No partial round key survives reset.
- States: IDLE, EMIT. All outputs are registered.
- IDLE:
  - busy=0, rk_valid=0.
  - On start=1: round_key<=key_in, rk_round<=0, rk_valid<=1, busy<=1, go to EMIT.
- EMIT, handshake fires when rk_valid && rk_ready:
  - rk_round<10: round_key<=next_key(round_key, rcon[rk_round+1]), rk_round<=rk_round+1. Stay in EMIT with rk_valid=1.
  - rk_round==10: last_key<=round_key, done<=1 for exactly one cycle, rk_valid<=0, busy<=0, go to IDLE.
- EMIT, rk_ready=0: round_key, rk_round and rk_valid hold unchanged. Stalls are unbounded.
- start while in EMIT is ignored. The expansion is not restarted and key_in is not resampled.
- start in the same cycle as the done pulse is accepted, because state is already IDLE. round_key then reloads on the following edge.
- next_key arithmetic:
  - w0..w3 = round_key[127:96], [95:64], [63:32], [31:0].
  - temp = SubWord(RotWord(w3)) XOR {rcon, 24'h0}. RotWord is a left byte rotate.
  - n0=w0^temp, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36. Index 0 is unused.
- Latency with rk_ready held high and start accepted at edge t:
  - round 0 is valid from t+1; round N is valid at t+1+N.
  - round 10 is accepted at edge t+11; done and last_key update at t+12.
- rk_round never exceeds 10 and never wraps.

Decomposition:
- Package aes128_pkg:
  - RCON table (10x8-bit constant).
  - NUM_ROUNDS constant.
  - Typedefs: word_t (32-bit), block_t (128-bit), state enum {IDLE, EMIT}.
  - SBOX constant table, shared with the Subbytes logic.
- Sub-module aes_sbox_byte: combinational 8-bit S-box lookup, instantiated 4x for SubWord.
- The schedule module holds the FSM, counter, registers and next_key XOR network.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at t+11; done pulse at t+12; last_key = round 10.
- All-zero key, rk_ready=1 → round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; busy high t+1..t+11.
- Same FIPS key, rk_ready toggled randomly (including a 20-cycle stall at round 5) → the same 11-key sequence in order; round_key/rk_round stable during stalls; exactly one done pulse.
- start pulsed again during EMIT with a different key_in → ignored; sequence completes with the original key. Back-to-back start in the done cycle → new expansion begins; last_key holds the previous round 10 until its own completion.
- rst_n asserted asynchronously mid-round 6 → all outputs zero immediately with no clock edge. After release, a fresh start produces the correct full sequence.
